// File: rtl/uart_rx_pkg.sv
// Shared definitions for the parametrised UART receiver.
//   uart_rx_state_e : receiver FSM states
//   PAR_*           : parity_mode_i encodings (2'b11 also means no parity)
//   parity_on()     : decode whether a mode carries a parity bit
//   parity_bad()    : parity check of a received frame
package uart_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } uart_rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Both 2'b00 and 2'b11 mean "no parity bit".
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode != PAR_NONE) && (mode != ~PAR_NONE);
    endfunction

    // data_xor is the XOR of all data bits, par_bit the received parity bit.
    function automatic logic parity_bad(input logic [1:0] mode, input logic data_xor,
                                        input logic par_bit);
        return (mode == PAR_EVEN) ? (data_xor ^ par_bit) : !(data_xor ^ par_bit);
    endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous FIFO holding received characters.
//   clk_i, rst_i      clock, synchronous active-high reset (empties the FIFO)
//   push_i/push_data_i write request and data; ignored when full unless a pop happens too
//   pop_i             read request; ignored when empty
//   rd_data_o         head entry, 0 while empty
//   full_o, empty_o   status
//   drop_o            push rejected because the FIFO is full and not popping
//   level_o           occupancy, 0..DEPTH
module uart_rx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     drop_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW + 1)'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same clk frees the slot, so a push into a full FIFO still succeeds.
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok;

    assign rd_data_o = empty_o ? '0 : mem_q[rptr_q];
    assign level_o   = level_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push_ok) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_gen.sv
// Parametrised UART receiver with RX FIFO.
// Optional feature macro: UART_RX_PARITY_EN (parity bit reception and parity_err_o).
//   clk_i, rst_i     clock, synchronous active-high reset
//   rx_tick_i        oversample strobe, OVERSAMPLE per bit period
//   rx_i             synchronised serial input, idle high
//   rx_en_i          receiver enable; low aborts any partial frame
//   stop2_i          two stop bits expected
//   parity_mode_i    00/11 none, 01 even, 10 odd
//   rd_data_o        FIFO head, rd_valid_o FIFO not empty, rd_ready_i pops
//   frame_err_o      pulse with the commit of a frame whose stop bit(s) sampled low
//   parity_err_o     pulse with the commit of a frame whose parity mismatched
//   overrun_o        pulse when a committed frame is dropped because the FIFO is full
//   level_o          FIFO occupancy
module uart_rx_fifo_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          rx_tick_i,
    input  logic                          rx_i,
    input  logic                          rx_en_i,
    input  logic                          stop2_i,
    input  logic [1:0]                    parity_mode_i,
    output logic [DATA_BITS-1:0]          rd_data_o,
    output logic                          rd_valid_o,
    input  logic                          rd_ready_i,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          overrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CntLast = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CntHalf = CW'(OVERSAMPLE / 2 - 1);

    uart_rx_state_e       state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 stop2_q, stop2_d;
`ifdef UART_RX_PARITY_EN
    logic [1:0]           par_mode_q, par_mode_d;
    logic                 perr_q, perr_d;
`else
    logic                 unused_parity_mode;
    assign unused_parity_mode = ^parity_mode_i;
`endif

    logic push;
    logic commit;
    logic commit_fe;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_drop;
    logic cnt_at_last;

    assign cnt_at_last = (cnt_q == CntLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        ferr_d    = ferr_q;
        stop2_d   = stop2_q;
`ifdef UART_RX_PARITY_EN
        par_mode_d = par_mode_q;
        perr_d     = perr_q;
`endif
        commit    = 1'b0;
        commit_fe = 1'b0;

        if (!rx_en_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = '0;
            ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end else if (rx_tick_i) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_i) begin
                        state_d = StStart;
                        cnt_d   = '0;
                        bit_d   = '0;
                        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end
                StStart: begin
                    if (cnt_q == CntHalf) begin
                        // Counter restarts here so later samples land mid-bit.
                        cnt_d = '0;
                        if (!rx_i) begin
                            state_d = StData;
                            stop2_d = stop2_i;
`ifdef UART_RX_PARITY_EN
                            par_mode_d = parity_mode_i;
`endif
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        shift_d = {rx_i, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BW'(DATA_BITS - 1)) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = parity_on(par_mode_q) ? StParity : StStop1;
`else
                            state_d = StStop1;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (cnt_at_last) begin
                        cnt_d   = '0;
                        perr_d  = parity_bad(par_mode_q, ^shift_q, rx_i);
                        state_d = StStop1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                StStop1: begin
                    if (cnt_at_last) begin
                        cnt_d = '0;
                        if (stop2_q) begin
                            ferr_d  = ~rx_i;
                            state_d = StStop2;
                        end else begin
                            commit    = 1'b1;
                            commit_fe = ~rx_i;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StStop2: begin
                    if (cnt_at_last) begin
                        cnt_d     = '0;
                        commit    = 1'b1;
                        commit_fe = ferr_q | ~rx_i;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase

            // Commit happens mid stop bit; returning to idle now keeps the next start edge.
            if (commit) begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end
    end

    assign push        = commit;
    assign frame_err_o = commit & commit_fe;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = commit & perr_q;
`else
    assign parity_err_o = 1'b0;
`endif
    assign overrun_o  = fifo_drop;
    assign rd_valid_o = ~fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            stop2_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_mode_q <= PAR_NONE;
            perr_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            stop2_q <= stop2_d;
`ifdef UART_RX_PARITY_EN
            par_mode_q <= par_mode_d;
            perr_q     <= perr_d;
`endif
        end
    end

    uart_rx_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_data_i(shift_q),
        .pop_i      (rd_ready_i),
        .rd_data_o  (rd_data_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .drop_o     (fifo_drop),
        .level_o    (level_o)
    );

    // Full status is only consumed through drop_o.
    logic unused_fifo_full;
    assign unused_fifo_full = fifo_full;

endmodule
